// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl -- sequencer for the AES-128 KeyExpansion datapath.
//
// Purpose:
//   An accepted start latches a 128-bit cipher key as round key 0. One
//   KeyExpansion round is then computed per clock for rounds 1..NROUNDS,
//   and every round key is kept in an internal register file. The stored
//   keys are served to the cipher round engine through a combinational
//   read port.
//
// Ports:
//   clk          in   1         single clock, rising edge
//   reset        in   1         synchronous, active-high; wins over everything
//   start        in   1         new schedule request, honoured in IDLE/DONE only
//   cipher_Key   in   SENTENCE  key sampled on the accepted start edge
//   rd_Round     in   4         round key index to read (0..NROUNDS)
//   rd_Key       out  SENTENCE  stored key for rd_Round, 0 beyond NROUNDS
//   busy         out  1         high while rounds are being generated
//   done         out  1         one-cycle pulse when round NROUNDS is written
//   keys_Valid   out  1         all round keys stored and stable
//
// Word order inside a key: [SENTENCE-1 -: WORD] is w0, [WORD-1:0] is w3.

// key_expansion -- one purely combinational AES-128 KeyExpansion round.
//   round_Key     in   SENTENCE  previous round key
//   round_Number  in   4         round being produced (1..10)
//   next_Key      out  SENTENCE  round key for round_Number
module key_expansion #(
    parameter int BYTE     = 8,
    parameter int WORD     = 32,
    parameter int SENTENCE = 128
) (
    input  logic [SENTENCE-1:0] round_Key,
    input  logic [3:0]          round_Number,
    output logic [SENTENCE-1:0] next_Key
);

    // Forward AES S-box; element 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam int NBYTES = WORD / BYTE;

    // Round constant byte; rounds outside 1..10 contribute nothing.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    logic [WORD-1:0] w0_s, w1_s, w2_s, w3_s;
    logic [WORD-1:0] rot_s, sub_s, temp_s;
    logic [WORD-1:0] n0_s, n1_s, n2_s, n3_s;

    assign w0_s = round_Key[SENTENCE-1 -: WORD];
    assign w1_s = round_Key[SENTENCE-WORD-1 -: WORD];
    assign w2_s = round_Key[SENTENCE-2*WORD-1 -: WORD];
    assign w3_s = round_Key[WORD-1:0];

    // RotWord: cyclic left shift of w3 by one byte.
    assign rot_s = {w3_s[WORD-BYTE-1:0], w3_s[WORD-1 -: BYTE]};

    // SubWord: S-box applied to every byte of the rotated word.
    always_comb begin
        sub_s = {WORD{1'b0}};
        for (int b = 0; b < NBYTES; b++) begin
            sub_s[b*BYTE +: BYTE] = SBOX[rot_s[b*BYTE +: BYTE]];
        end
    end

    assign temp_s = sub_s ^ {rcon(round_Number), {(WORD-BYTE){1'b0}}};

    // Each new word chains off the previous new word.
    assign n0_s = w0_s ^ temp_s;
    assign n1_s = w1_s ^ n0_s;
    assign n2_s = w2_s ^ n1_s;
    assign n3_s = w3_s ^ n2_s;

    assign next_Key = {n0_s, n1_s, n2_s, n3_s};

endmodule

module key_schedule_ctrl #(
    parameter int BYTE     = 8,
    parameter int WORD     = 32,
    parameter int SENTENCE = 128,
    parameter int NROUNDS  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SENTENCE-1:0] cipher_Key,
    input  logic [3:0]          rd_Round,
    output logic [SENTENCE-1:0] rd_Key,
    output logic                busy,
    output logic                done,
    output logic                keys_Valid
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [3:0]          cnt_r, cnt_nxt_s;
    logic                busy_r, done_r, valid_r;
    logic                done_nxt_s, valid_nxt_s;
    logic                wr_en_s;
    logic [3:0]          wr_idx_s;
    logic [3:0]          prev_idx_s;
    logic [SENTENCE-1:0] wr_data_s;
    logic [SENTENCE-1:0] prev_key_s;
    logic [SENTENCE-1:0] exp_key_s;
    logic [SENTENCE-1:0] key_file_r [0:NROUNDS];

    // Previous round key feeding the expansion (key[cnt-1]).
    always_comb begin
        prev_idx_s = cnt_r - 4'd1;
        if (prev_idx_s <= LAST_ROUND) begin
            prev_key_s = key_file_r[prev_idx_s];
        end else begin
            prev_key_s = {SENTENCE{1'b0}};
        end
    end

    key_expansion #(
        .BYTE     (BYTE),
        .WORD     (WORD),
        .SENTENCE (SENTENCE)
    ) u_key_expansion (
        .round_Key    (prev_key_s),
        .round_Number (cnt_r),
        .next_Key     (exp_key_s)
    );

    // Next-state, counter, flag and register-file write decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        valid_nxt_s = valid_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = 4'd0;
        wr_data_s   = {SENTENCE{1'b0}};
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    wr_en_s     = 1'b1;
                    wr_idx_s    = 4'd0;
                    wr_data_s   = cipher_Key;
                    cnt_nxt_s   = 4'd1;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_EXPAND;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_EXPAND: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = cnt_r;
                wr_data_s = exp_key_s;
                // cnt parks at the last round instead of wrapping.
                if (cnt_r == LAST_ROUND) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                    valid_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_EXPAND);
            done_r  <= done_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Round-key register file: one write per cycle at most.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NROUNDS; i++) begin
                key_file_r[i] <= {SENTENCE{1'b0}};
            end
        end else if (wr_en_s && (wr_idx_s <= LAST_ROUND)) begin
            key_file_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Combinational read port; indices past the last round read as zero.
    always_comb begin
        if (rd_Round <= LAST_ROUND) begin
            rd_Key = key_file_r[rd_Round];
        end else begin
            rd_Key = {SENTENCE{1'b0}};
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign keys_Valid = valid_r;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: directed scenarios followed by
// randomized start/reset/read traffic, compared against a word-oriented
// AES-128 key-schedule model with an S-box derived from GF(2^8) arithmetic.
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] cipher_Key;
    logic [3:0]   rd_Round;
    logic [127:0] rd_Key;
    logic         busy;
    logic         done;
    logic         keys_Valid;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] sched_m  [0:10];
    logic [127:0] m_keys   [0:10];
    int           m_left   = 0;
    logic         m_done   = 1'b0;
    logic         m_valid  = 1'b0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_schedule_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cipher_Key (cipher_Key),
        .rd_Round   (rd_Round),
        .rd_Key     (rd_Key),
        .busy       (busy),
        .done       (done),
        .keys_Valid (keys_Valid)
    );

    always #50 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[x] = s;
        end
    endtask

    // FIPS-197 word-array key expansion: w[i] = w[i-4] ^ f(w[i-1]).
    task automatic build_sched(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Behaviour at one rising edge, from the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 11; i++) m_keys[i] = 128'h0;
            m_left = 0; m_done = 1'b0; m_valid = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_keys[11 - m_left] = sched_m[11 - m_left];
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1; m_valid = 1'b1;
                end
            end else if (start) begin
                build_sched(cipher_Key);
                m_keys[0] = cipher_Key;
                m_left = 10; m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [127:0] exp_rd(input logic [3:0] idx);
        return (idx <= 4'd10) ? m_keys[idx] : 128'h0;
    endfunction

    task automatic check_all();
        chk("busy", 128'(busy), 128'(m_left > 0));
        chk("done", 128'(done), 128'(m_done));
        chk("keys_valid", 128'(keys_Valid), 128'(m_valid));
        chk("rd_key", rd_Key, exp_rd(rd_Round));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic check_reads();
        logic [3:0] save = rd_Round;
        for (int i = 0; i < 16; i++) begin
            rd_Round = 4'(i);
            #1;
            chk("rd_sweep", rd_Key, exp_rd(4'(i)));
        end
        rd_Round = save;
        #1;
    endtask

    task automatic read_const(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rd_Round = idx;
        #1;
        chk(tag, rd_Key, exp);
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int busy_cnt, done_cnt, done_edge, last_done;
        build_sbox();
        reset = 1'b1; start = 1'b0; cipher_Key = 128'h0; rd_Round = 4'd0;

        // 1: reset state, then the FIPS-197 example key.
        step(); step();
        check_reads();
        reset = 1'b0;
        cipher_Key = FIPS_KEY; start = 1'b1;
        step();
        start = 1'b0; cipher_Key = rnd_key();
        busy_cnt = busy ? 1 : 0; done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        chk("busy_cycles", 128'(busy_cnt), 128'd10);
        chk("done_pulses", 128'(done_cnt), 128'd1);
        read_const(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        read_const(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
        read_const(4'd0, FIPS_KEY, "fips_rk0");
        check_reads();

        // 2: start pulsed on the 4th EXPAND cycle must be ignored.
        cipher_Key = FIPS_KEY; start = 1'b1;
        step();
        done_edge = 0;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 4);
            cipher_Key = (k == 4) ? rnd_key() : FIPS_KEY;
            step();
            if (done) done_edge = k;
        end
        start = 1'b0;
        chk("ignored_start_done_edge", 128'(done_edge), 128'd10);
        read_const(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ignored_start_rk10");

        // 3: restart from DONE with the all-zero key.
        cipher_Key = 128'h0; start = 1'b1;
        step();
        chk("valid_drop_on_accept", 128'(keys_Valid), 128'd0);
        start = 1'b0;
        repeat (10) step();
        read_const(4'd1, 128'h62636363626363636263636362636363, "zero_rk1");
        read_const(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        // 4: reset on the 5th EXPAND cycle clears everything.
        cipher_Key = rnd_key(); start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_mid_busy", 128'(busy), 128'd0);
        chk("reset_mid_valid", 128'(keys_Valid), 128'd0);
        check_reads();

        // 5: out-of-range read indices after a completed schedule.
        cipher_Key = rnd_key(); start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        read_const(4'd11, 128'h0, "rd_idx11");
        read_const(4'd15, 128'h0, "rd_idx15");
        check_reads();

        // 6: start held high restarts every 11 cycles.
        start = 1'b1; last_done = -1; done_cnt = 0;
        for (int k = 0; k < 45; k++) begin
            cipher_Key = rnd_key();
            rd_Round = 4'($urandom_range(0, 15));
            step();
            if (done) begin
                done_cnt++;
                if (last_done >= 0) chk("done_period", 128'(cyc - last_done), 128'd11);
                last_done = cyc;
            end
        end
        chk("held_start_done_count", 128'(done_cnt), 128'd4);
        start = 1'b0;
        repeat (12) step();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 5) == 0);
            cipher_Key = rnd_key();
            rd_Round = 4'($urandom_range(0, 15));
            step();
            if (k % 50 == 0) check_reads();
        end
        reset = 1'b0; start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
